// File: rtl/ram256_bist.sv
// March C- BIST initiator for a single-port RAM256 macro.
// When idle, the system port passes straight through to the RAM.
module ram256_bist #(
  parameter int WSIZE = 4
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [7:0]           fail_addr,
  output logic [2:0]           fail_elem,
  output logic [7:0]           fail_cnt,
  input  logic                 sys_en,
  input  logic [WSIZE-1:0]     sys_we,
  input  logic [7:0]           sys_a,
  input  logic [WSIZE*8-1:0]   sys_di,
  output logic [WSIZE*8-1:0]   sys_do,
  output logic                 EN0,
  output logic [WSIZE-1:0]     WE0,
  output logic [7:0]           A0,
  output logic [WSIZE*8-1:0]   Di0,
  input  logic [WSIZE*8-1:0]   Do0
);

  localparam int DW = WSIZE * 8;

  // state | meaning
  // IDLE  | port released to sys_*, no result yet
  // RUN   | walking March C- elements E0..E5
  // DRAIN | final compare of the last E5 read, RAM disabled
  // DONE  | port released, results held
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t          state, state_nxt;
  logic [2:0]      elem, elem_nxt;
  logic [7:0]      addr, addr_nxt;
  logic            phase, phase_nxt;

  logic            accept;
  logic            descending;
  logic            single_op;
  logic            rd_op;
  logic            op_last;
  logic            last_addr;
  logic [DW-1:0]   bg_wr;
  logic [DW-1:0]   bg_rd;

  logic            bist_en;
  logic [WSIZE-1:0] bist_we;
  logic [DW-1:0]   bist_di;

  logic            cmp_vld;
  logic [DW-1:0]   cmp_exp;
  logic [7:0]      cmp_addr;
  logic [2:0]      cmp_elem;
  logic            first_seen;
  logic            mismatch;

  assign busy       = (state == S_RUN) || (state == S_DRAIN);
  assign accept     = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign descending = (elem == 3'd3) || (elem == 3'd4);
  assign single_op  = (elem == 3'd0) || (elem == 3'd5);
  // E5 is read-only; read-write elements read in phase 0, write in phase 1
  assign rd_op      = (elem == 3'd5) || (!single_op && !phase);
  assign op_last    = single_op || phase;
  assign last_addr  = descending ? (addr == 8'h00) : (addr == 8'hFF);
  assign bg_wr      = elem[0] ? {DW{1'b1}} : {DW{1'b0}};
  assign bg_rd      = ((elem == 3'd2) || (elem == 3'd4)) ? {DW{1'b1}} : {DW{1'b0}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= S_IDLE;
      elem  <= 3'd0;
      addr  <= 8'd0;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      elem  <= elem_nxt;
      addr  <= addr_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    addr_nxt  = addr;
    phase_nxt = phase;
    bist_en   = 1'b0;
    bist_we   = '0;
    bist_di   = bg_wr;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_nxt = S_RUN;
          elem_nxt  = 3'd0;
          addr_nxt  = 8'd0;
          phase_nxt = 1'b0;
        end
      end
      S_RUN: begin
        bist_en = 1'b1;
        bist_we = rd_op ? '0 : '1;
        if (!op_last) begin
          phase_nxt = 1'b1;
        end else begin
          phase_nxt = 1'b0;
          if (!last_addr) begin
            addr_nxt = descending ? (addr - 8'd1) : (addr + 8'd1);
          end else if (elem == 3'd5) begin
            state_nxt = S_DRAIN;
            addr_nxt  = 8'd0;
          end else begin
            elem_nxt = elem + 3'd1;
            addr_nxt = ((elem == 3'd2) || (elem == 3'd3)) ? 8'hFF : 8'h00;
          end
        end
      end
      S_DRAIN: begin
        state_nxt = S_DONE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign EN0    = busy ? bist_en : sys_en;
  assign WE0    = busy ? bist_we : sys_we;
  assign A0     = busy ? addr    : sys_a;
  assign Di0    = busy ? bist_di : sys_di;
  assign sys_do = Do0;

  // Read data returns one cycle late, so expectation travels with it
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cmp_vld  <= 1'b0;
      cmp_exp  <= '0;
      cmp_addr <= 8'd0;
      cmp_elem <= 3'd0;
    end else begin
      cmp_vld <= (state == S_RUN) && rd_op;
      if ((state == S_RUN) && rd_op) begin
        cmp_exp  <= bg_rd;
        cmp_addr <= addr;
        cmp_elem <= elem;
      end
    end
  end

  assign mismatch = cmp_vld && (Do0 != cmp_exp);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      done       <= 1'b0;
      pass       <= 1'b0;
      fail_addr  <= 8'd0;
      fail_elem  <= 3'd0;
      fail_cnt   <= 8'd0;
      first_seen <= 1'b0;
    end else if (accept) begin
      done       <= 1'b0;
      pass       <= 1'b1;
      fail_addr  <= 8'd0;
      fail_elem  <= 3'd0;
      fail_cnt   <= 8'd0;
      first_seen <= 1'b0;
    end else begin
      if (mismatch) begin
        pass <= 1'b0;
        if (fail_cnt != 8'hFF) fail_cnt <= fail_cnt + 8'd1;
        if (!first_seen) begin
          first_seen <= 1'b1;
          fail_addr  <= cmp_addr;
          fail_elem  <= cmp_elem;
        end
      end
      if (state == S_DRAIN) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram256_bist.sv
// Bench for ram256_bist: behavioural RAM with injectable faults, an
// operation-level March C- model, and a per-cycle port/result checker.
module tb_ram256_bist;

  localparam int FM_NONE  = 0;
  localparam int FM_STUCK = 1;
  localparam int FM_ALIAS = 2;
  localparam int FM_FORCE = 3;

  logic        CLK, RST, start;
  logic        busy, done, pass;
  logic [7:0]  fail_addr, fail_cnt;
  logic [2:0]  fail_elem;
  logic        sys_en;
  logic [3:0]  sys_we;
  logic [7:0]  sys_a;
  logic [31:0] sys_di, sys_do;
  logic        EN0;
  logic [3:0]  WE0;
  logic [7:0]  A0;
  logic [31:0] Di0, Do0;

  int checks = 0;
  int errors = 0;
  int fault  = FM_NONE;

  typedef struct {
    bit          we;
    logic [7:0]  a;
    logic [31:0] d;
    logic [2:0]  e;
  } op_t;
  op_t ops[$];

  logic [31:0] mem[256];
  logic [31:0] gm[256];
  logic [31:0] rd_word;

  bit          g_pass;
  int          g_cnt;
  logic [7:0]  g_addr;
  logic [2:0]  g_elem;

  int busy_cyc = 0;
  bit prev_busy = 0;

  ram256_bist #(.WSIZE(4)) dut (
    .CLK(CLK), .RST(RST), .start(start),
    .busy(busy), .done(done), .pass(pass),
    .fail_addr(fail_addr), .fail_elem(fail_elem), .fail_cnt(fail_cnt),
    .sys_en(sys_en), .sys_we(sys_we), .sys_a(sys_a), .sys_di(sys_di),
    .sys_do(sys_do),
    .EN0(EN0), .WE0(WE0), .A0(A0), .Di0(Di0), .Do0(Do0)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // March C- as an ordered list of RAM operations
  task automatic build_ops();
    op_t o;
    ops.delete();
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < 256; k++) begin
        o.e = 3'(e);
        o.a = (e == 3 || e == 4) ? 8'(255 - k) : 8'(k);
        if (e != 0) begin
          o.we = 1'b0;
          o.d  = (e == 2 || e == 4) ? 32'hFFFF_FFFF : 32'h0;
          ops.push_back(o);
        end
        if (e != 5) begin
          o.we = 1'b1;
          o.d  = (e % 2 == 1) ? 32'hFFFF_FFFF : 32'h0;
          ops.push_back(o);
        end
      end
    end
  endtask

  // Replays the operation list on a faulty memory to get the expected verdict
  task automatic golden(input int mode);
    logic [31:0] r;
    bit first;
    first  = 0;
    g_pass = 1;
    g_cnt  = 0;
    g_addr = 8'h00;
    g_elem = 3'd0;
    for (int i = 0; i < 256; i++) gm[i] = 32'h0;
    foreach (ops[i]) begin
      if (ops[i].we) begin
        gm[ops[i].a] = ops[i].d;
        if (mode == FM_ALIAS && ops[i].a == 8'h81) gm[1] = ops[i].d;
      end else begin
        r = gm[ops[i].a];
        if (mode == FM_STUCK && ops[i].a == 8'h3C) r[5] = 1'b1;
        if (mode == FM_FORCE) r = 32'h5A5A_5A5A;
        if (r != ops[i].d) begin
          g_pass = 0;
          if (g_cnt < 255) g_cnt++;
          if (!first) begin
            first  = 1;
            g_addr = ops[i].a;
            g_elem = ops[i].e;
          end
        end
      end
    end
  endtask

  // Behavioural RAM256 with fault injection
  always @(posedge CLK) begin
    if (EN0) begin
      if (WE0 != 4'h0) begin
        for (int b = 0; b < 4; b++) begin
          if (WE0[b]) begin
            mem[A0][8*b +: 8] = Di0[8*b +: 8];
            if (fault == FM_ALIAS && A0 == 8'h81) mem[1][8*b +: 8] = Di0[8*b +: 8];
          end
        end
      end else begin
        rd_word = mem[A0];
        if (fault == FM_STUCK && A0 == 8'h3C) rd_word[5] = 1'b1;
        if (fault == FM_FORCE) rd_word = 32'h5A5A_5A5A;
        Do0 <= rd_word;
      end
    end
  end

  // Per-cycle checker
  always @(negedge CLK) begin
    chk("sys_do", sys_do, Do0);
    if (RST) begin
      chk("rst_busy", busy, 0);
      chk("rst_en0", EN0, sys_en);
      busy_cyc  = 0;
      prev_busy = 0;
    end else begin
      if (!busy) begin
        chk("mux_en", EN0, sys_en);
        chk("mux_we", WE0, sys_we);
        chk("mux_a", A0, sys_a);
        chk("mux_di", Di0, sys_di);
      end else begin
        if (busy_cyc < 2560) begin
          chk($sformatf("op%0d_en", busy_cyc), EN0, 1);
          chk($sformatf("op%0d_we", busy_cyc), WE0, ops[busy_cyc].we ? 4'hF : 4'h0);
          chk($sformatf("op%0d_a", busy_cyc), A0, ops[busy_cyc].a);
          if (ops[busy_cyc].we) chk($sformatf("op%0d_di", busy_cyc), Di0, ops[busy_cyc].d);
        end else if (busy_cyc == 2560) begin
          chk("drain_en", EN0, 0);
        end else begin
          chk("busy_overrun", busy_cyc, 2560);
        end
        busy_cyc++;
      end
      if (prev_busy && !busy) begin
        chk("run_len", busy_cyc, 2561);
        chk("end_done", done, 1);
        chk("end_pass", pass, g_pass);
        chk("end_cnt", fail_cnt, g_cnt);
        if (!g_pass) begin
          chk("end_addr", fail_addr, g_addr);
          chk("end_elem", fail_elem, g_elem);
        end
        busy_cyc = 0;
      end
      prev_busy = busy;
    end
  end

  task automatic pulse_start();
    @(posedge CLK); #1 start = 1'b1;
    @(posedge CLK); #1 start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (done !== 1'b1 && n < 3000) begin
      @(posedge CLK); #1;
      n++;
    end
    chk("run_completes", done, 1);
    @(negedge CLK); #1;
  endtask

  task automatic run_bist(input int mode, input bit noise);
    golden(mode);
    fault = mode;
    pulse_start();
    chk("start_busy", busy, 1);
    chk("start_done", done, 0);
    chk("start_pass", pass, 1);
    chk("start_cnt", fail_cnt, 0);
    if (noise) begin
      repeat (100) @(posedge CLK);
      #1;
      sys_en = 1'b1; sys_we = 4'hF; sys_a = 8'h55; sys_di = 32'h1234_5678;
      pulse_start();
      repeat (10) @(posedge CLK);
      #1;
      sys_en = 1'b0; sys_we = 4'h0; sys_a = 8'h00; sys_di = 32'h0;
    end
    wait_done();
    chk("post_busy", busy, 0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    Do0    = 32'h0;
    RST    = 1'b1;
    start  = 1'b0;
    sys_en = 1'b0;
    sys_we = 4'h0;
    sys_a  = 8'h00;
    sys_di = 32'h0;
    build_ops();

    repeat (3) @(posedge CLK);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_pass", pass, 0);
    chk("reset_fail_addr", fail_addr, 0);
    chk("reset_fail_elem", fail_elem, 0);
    chk("reset_fail_cnt", fail_cnt, 0);
    RST = 1'b0;

    // idle pass-through write then read
    @(posedge CLK); #1;
    sys_en = 1'b1; sys_we = 4'hF; sys_a = 8'h10; sys_di = 32'hDEAD_BEEF;
    @(posedge CLK); #1;
    sys_we = 4'h0;
    @(posedge CLK); #1;
    chk("passthru_rd", sys_do, 32'hDEAD_BEEF);
    sys_en = 1'b0; sys_a = 8'h00; sys_di = 32'h0;

    // clean run with ignored start and sys traffic mid-run
    run_bist(FM_NONE, 1);
    chk("clean_pass", pass, 1);
    chk("clean_cnt", fail_cnt, 0);

    // bit 5 of word 0x3C stuck at 1; restart straight from DONE
    run_bist(FM_STUCK, 0);
    chk("stuck_pass", pass, 0);
    chk("stuck_addr", fail_addr, 8'h3C);
    chk("stuck_elem", fail_elem, 3'd1);
    chk("stuck_cnt", fail_cnt, 8'd3);

    // writes to 0x81 also land in 0x01: first visible in E3 at 0x01, again in E4
    run_bist(FM_ALIAS, 0);
    chk("alias_pass", pass, 0);
    chk("alias_addr", fail_addr, 8'h01);
    chk("alias_elem", fail_elem, 3'd3);
    chk("alias_cnt", fail_cnt, 8'd2);

    // every read mismatches: 1280 reads saturate the counter
    run_bist(FM_FORCE, 0);
    chk("force_pass", pass, 0);
    chk("force_addr", fail_addr, 8'h00);
    chk("force_elem", fail_elem, 3'd1);
    chk("force_cnt", fail_cnt, 8'hFF);

    // reset in the middle of a failing run, then a clean rerun
    golden(FM_FORCE);
    fault = FM_FORCE;
    pulse_start();
    repeat (999) @(posedge CLK);
    #1;
    chk("mid_busy_before_rst", busy, 1);
    RST = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_en0", EN0, sys_en);
    @(posedge CLK); #1;
    chk("midrst_done", done, 0);
    chk("midrst_pass", pass, 0);
    chk("midrst_cnt", fail_cnt, 0);
    chk("midrst_addr", fail_addr, 0);
    RST = 1'b0;
    @(posedge CLK); #1;
    run_bist(FM_NONE, 0);
    chk("rerun_pass", pass, 1);
    chk("rerun_cnt", fail_cnt, 0);

    repeat (3) @(posedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
